// File: rtl/stack_arbiter_pkg.sv
// stack_arbiter_pkg: shared state encodings, op codes and depth helper
package stack_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;

    localparam int DEF_ADDR_SPACE_EXP = 2;
    localparam int DEF_STACK_DEPTH    = 2 ** DEF_ADDR_SPACE_EXP;

    function automatic int stack_depth(input int addr_space_exp);
        return 2 ** addr_space_exp;
    endfunction

endpackage

// File: rtl/stack.sv
// stack: LIFO of 2**ADDR_SPACE_EXP words with registered pop data
module stack
    import stack_arbiter_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int ADDR_SPACE_EXP = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic                      pop,
    input  logic [DATA_SIZE-1:0]      push_data_in,
    output logic [DATA_SIZE-1:0]      pop_data_out,
    output logic [ADDR_SPACE_EXP:0]   count,
    output logic                      empty,
    output logic                      full
);

    localparam int DEPTH = stack_depth(ADDR_SPACE_EXP);

    logic [DATA_SIZE-1:0]    mem_q [DEPTH];
    logic [ADDR_SPACE_EXP:0] count_q, count_d, top;
    logic [DATA_SIZE-1:0]    pop_data_q, pop_data_d;
    logic                    do_push, do_pop;

    // occupancy flags, guarded strobes and next pointer/data
    always_comb begin
        empty      = count_q == '0;
        full       = count_q[ADDR_SPACE_EXP];
        do_push    = push & ~full;
        do_pop     = pop & ~empty & ~do_push;
        top        = count_q - 1'b1;
        count_d    = do_push ? count_q + 1'b1 : do_pop ? top : count_q;
        pop_data_d = do_pop ? mem_q[top[ADDR_SPACE_EXP-1:0]] : pop_data_q;
    end

    // pointer and popped-word registers
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= '0;
            pop_data_q <= '0;
        end else begin
            count_q    <= count_d;
            pop_data_q <= pop_data_d;
        end
    end

    // storage is not reset; an empty pointer makes old words unreachable
    always_ff @(posedge clk) begin
        if (do_push) mem_q[count_q[ADDR_SPACE_EXP-1:0]] <= push_data_in;
    end

    assign pop_data_out = pop_data_q;
    assign count        = count_q;

endmodule

// File: rtl/stack_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant with pointer advancing past the winner
module rr_arbiter #(
    parameter int NUM_CLIENTS = 2,
    parameter int IDX_W       = $clog2(NUM_CLIENTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_CLIENTS-1:0] req,
    input  logic                   advance,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [IDX_W-1:0]       idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;
    int               c;

    // scan from the pointer upward, wrapping, and take the first request
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            c = (int'(ptr_q) + i) % NUM_CLIENTS;
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = IDX_W'(c);
            end
        end
        ptr_d = advance ? ((int'(idx) == NUM_CLIENTS - 1) ? '0 : idx + 1'b1) : ptr_q;
    end

    // priority pointer moves only on a completed handshake
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/stack_arbiter.sv
// stack_arbiter: serialises client push/pop requests into one shared stack
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int ADDR_SPACE_EXP = 2,
    parameter int NUM_CLIENTS    = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_CLIENTS-1:0]           req_valid,
    input  logic [NUM_CLIENTS-1:0]           req_op,
    input  logic [NUM_CLIENTS*DATA_SIZE-1:0] req_data,
    output logic [NUM_CLIENTS-1:0]           req_ready,
    output logic [NUM_CLIENTS-1:0]           rsp_valid,
    output logic [DATA_SIZE-1:0]             rsp_data,
    output logic                             rsp_err,
    output logic [ADDR_SPACE_EXP:0]          count,
    output logic                             empty,
    output logic                             full
);

    localparam int IDX_W = $clog2(NUM_CLIENTS);

    state_t                 state_q, state_d;
    logic                   op_q, op_d, err_q, err_d;
    logic [DATA_SIZE-1:0]   data_q, data_d, pop_data;
    logic [IDX_W-1:0]       client_q, client_d, idx;
    logic [NUM_CLIENTS-1:0] arb_req, grant;
    logic                   advance, st_push, st_pop;

    assign arb_req   = (state_q == ST_IDLE) ? req_valid : '0;
    assign req_ready = grant;
    assign advance   = |(req_valid & grant);

    rr_arbiter #(
        .NUM_CLIENTS(NUM_CLIENTS),
        .IDX_W      (IDX_W)
    ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (arb_req),
        .advance(advance),
        .grant  (grant),
        .idx    (idx)
    );

    stack #(
        .DATA_SIZE     (DATA_SIZE),
        .ADDR_SPACE_EXP(ADDR_SPACE_EXP)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push        (st_push),
        .pop         (st_pop),
        .push_data_in(data_q),
        .pop_data_out(pop_data),
        .count       (count),
        .empty       (empty),
        .full        (full)
    );

    // state and captured request registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_POP;
            err_q    <= 1'b0;
            data_q   <= '0;
            client_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            err_q    <= err_d;
            data_q   <= data_d;
            client_q <= client_d;
        end
    end

    // next state; capture on handshake, judge the error while executing
    always_comb begin
        state_d  = (state_q == ST_IDLE) ? (advance ? ST_EXEC : ST_IDLE) :
                   (state_q == ST_EXEC) ? ST_RESP : ST_IDLE;
        op_d     = (state_q == ST_IDLE && advance) ? req_op[idx] : op_q;
        data_d   = (state_q == ST_IDLE && advance) ? req_data[int'(idx)*DATA_SIZE +: DATA_SIZE] : data_q;
        client_d = (state_q == ST_IDLE && advance) ? idx : client_q;
        err_d    = (state_q == ST_EXEC) ? ((op_q == OP_PUSH) ? full : empty) : err_q;
    end

    // stack strobes in EXEC, one-cycle response in RESP
    always_comb begin
        st_push   = (state_q == ST_EXEC) && op_q == OP_PUSH && !full;
        st_pop    = (state_q == ST_EXEC) && op_q == OP_POP && !empty;
        rsp_valid = (state_q == ST_RESP) ? NUM_CLIENTS'(1) << client_q : '0;
        rsp_data  = (state_q == ST_RESP && op_q == OP_POP && !err_q) ? pop_data : '0;
        rsp_err   = (state_q == ST_RESP) && err_q;
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// tb_stack_arbiter: scoreboard bench with a reference LIFO model
module tb_stack_arbiter;

    typedef struct {
        int         client;
        logic [7:0] data;
        logic       err;
        int         cnt;
        int         hs;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_op, req_ready, rsp_valid;
    logic [15:0] req_data;
    logic [7:0]  rsp_data;
    logic        rsp_err, empty, full;
    logic [2:0]  count;

    int         total, bad, g1;
    int         cyc = 0;
    int         rem[2];
    int         grants[$];
    exp_t       sb[$];
    logic [7:0] mdl[$];
    logic [7:0] rsp_log[$];
    logic [7:0] lifo_in[4]  = '{8'h00, 8'hF0, 8'h0F, 8'hAA};
    logic [7:0] lifo_exp[4] = '{8'hAA, 8'h0F, 8'hF0, 8'h00};

    stack_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_op   (req_op),
        .req_data (req_data),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_hs(input int i, input logic o, input logic [7:0] d);
        exp_t e;
        e.client = i;
        e.hs     = cyc;
        if (o) begin
            e.err  = mdl.size() == 4;
            e.data = 8'h00;
            if (!e.err) mdl.push_back(d);
        end else begin
            e.err  = mdl.size() == 0;
            e.data = e.err ? 8'h00 : mdl.pop_back();
        end
        e.cnt = mdl.size();
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid !== 2'b00) begin
            rsp_log.push_back(rsp_data);
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'd1 << e.client);
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("count", 32'(count), 32'(e.cnt));
                check("empty", 32'(empty), 32'(e.cnt == 0));
                check("full", 32'(full), 32'(e.cnt == 4));
                check("latency", 32'(cyc - e.hs), 32'd2);
            end
        end
        if (req_valid[1] && req_ready[1]) g1++;
    end

    task automatic do_reset;
        reset     = 1'b1;
        req_valid = 2'b00;
        rem       = '{0, 0};
        mdl.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic setc(input int i, input logic o, input logic [7:0] d, input int n);
        req_op[i]          = o;
        req_data[i*8 +: 8] = d;
        rem[i]             = n;
    endtask

    task automatic drain;
        int t = 0;
        while (sb.size() > 0 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check("drain", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic serve;
        int t = 0;
        for (int i = 0; i < 2; i++) req_valid[i] = rem[i] > 0;
        while ((rem[0] > 0 || rem[1] > 0) && t < 200) begin
            @(negedge clk);
            t++;
            for (int i = 0; i < 2; i++)
                if (req_valid[i] && req_ready[i]) begin
                    expect_hs(i, req_op[i], req_data[i*8 +: 8]);
                    grants.push_back(i);
                    rem[i]--;
                end
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) req_valid[i] = rem[i] > 0;
        end
        check("serve_timeout", 32'(t < 200), 32'd1);
        drain();
    endtask

    task automatic wait_hs(input int i);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(req_valid[i] && req_ready[i]) && t < 20);
        check("hs_wait", 32'(req_ready[i]), 32'd1);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        g1        = 0;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_op    = 2'b00;
        req_data  = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        setc(0, 1'b1, 8'hA5, 1);
        serve();
        check("push1_count", 32'(count), 32'd1);
        rsp_log.delete();
        setc(0, 1'b0, 8'h00, 1);
        serve();
        check("pop1_data", 32'(rsp_log.size() > 0 ? rsp_log[0] : 8'h00), 32'hA5);
        check("pop1_empty", 32'(empty), 32'd1);

        do_reset();
        grants.delete();
        setc(0, 1'b1, 8'h11, 2);
        setc(1, 1'b1, 8'h22, 2);
        serve();
        check("rr_n", grants.size(), 4);
        for (int i = 0; i < grants.size(); i++) check("rr_grant", grants[i], i % 2);
        check("rr_full", 32'(full), 32'd1);
        check("rr_count", 32'(count), 32'd4);

        setc(0, 1'b1, 8'hBC, 1);
        serve();
        check("ovf_count", 32'(count), 32'd4);
        rsp_log.delete();
        setc(1, 1'b0, 8'h00, 4);
        serve();
        check("ovf_top", 32'(rsp_log.size() > 0 ? rsp_log[0] : 8'h00), 32'h22);
        setc(0, 1'b0, 8'h00, 1);
        serve();
        check("unf_count", 32'(count), 32'd0);

        do_reset();
        foreach (lifo_in[i]) begin
            setc(0, 1'b1, lifo_in[i], 1);
            serve();
        end
        rsp_log.delete();
        setc(1, 1'b0, 8'h00, 4);
        serve();
        check("lifo_n", rsp_log.size(), 4);
        for (int i = 0; i < rsp_log.size() && i < 4; i++) check("lifo_data", 32'(rsp_log[i]), 32'(lifo_exp[i]));

        do_reset();
        setc(1, 1'b1, 8'h77, 0);
        req_valid = 2'b10;
        wait_hs(1);
        @(posedge clk);
        #1 req_valid = 2'b00;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        @(posedge clk);
        #1;
        grants.delete();
        setc(0, 1'b1, 8'h01, 1);
        setc(1, 1'b1, 8'h02, 1);
        serve();
        check("midrst_first", grants.size() > 0 ? grants[0] : -1, 0);

        do_reset();
        g1 = 0;
        setc(0, 1'b1, 8'h5A, 0);
        req_valid = 2'b01;
        wait_hs(0);
        expect_hs(0, 1'b1, 8'h5A);
        @(posedge clk);
        #1 req_valid = 2'b10;
        @(posedge clk);
        #1 req_valid = 2'b00;
        drain();
        repeat (3) @(negedge clk);
        check("wd_grant1", g1, 0);
        check("wd_ready", 32'(req_ready), 32'd0);
        check("wd_count", 32'(count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Round-robin arbiter that shares one LIFO stack instance among NUM_CLIENTS requesters.
- Each client issues push or pop requests over a valid/ready handshake.
- The arbiter serialises the requests into the stack and returns a one-cycle response to the issuing client, carrying pop data and an error flag.
- It sits between client logic and the stack; clients never drive the stack directly.

Parameters:
- DATA_SIZE, 8, word width; passed to the stack.
- ADDR_SPACE_EXP, 2, log2 of stack depth (depth 4 by default); passed to the stack.
- NUM_CLIENTS, 2, number of requesters; legal range 2..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset; also drives the stack's reset.
- req_valid  in  NUM_CLIENTS  per-client request valid.
- req_op  in  NUM_CLIENTS  per-client operation: 1 = push, 0 = pop.
- req_data  in  NUM_CLIENTS*DATA_SIZE  per-client push word; client i occupies bits [i*DATA_SIZE +: DATA_SIZE].
- req_ready  out  NUM_CLIENTS  one-hot grant; the handshake completes when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_CLIENTS  one-hot, one-cycle response strobe to the issuing client.
- rsp_data  out  DATA_SIZE  popped word; 0 for pushes and for errored pops.
- rsp_err  out  1  qualified by rsp_valid; 1 = push while full, or pop while empty.
- count  out  ADDR_SPACE_EXP+1  current stack occupancy.
- empty  out  1  stack empty flag, passed through.
- full  out  1  stack full flag, passed through.

Behaviour:
- Stack contract: push/pop are sampled on the rising edge. The popped word is registered at that edge and is valid on pop_data_out the following cycle.
- FSM, 3 states:
  - IDLE:
    - req_ready is the one-hot round-robin winner among asserted req_valid; it is combinational from req_valid and the priority pointer.
    - On handshake: capture op, data and client index, then go to EXEC.
    - No valid request: stay in IDLE with req_ready = 0.
  - EXEC:
    - Push with full = 0: assert stack push for one cycle with the captured data; err = 0.
    - Pop with empty = 0: assert stack pop for one cycle; err = 0.
    - Push when full, or pop when empty: no stack strobe, err = 1, stack contents unchanged.
    - Go to RESP.
  - RESP:
    - rsp_valid[client] = 1 for exactly one cycle.
    - rsp_data = pop_data_out for a successful pop, else 0.
    - rsp_err = err.
    - Go to IDLE.
- req_ready is 0 in EXEC and RESP; requests stay pending, and clients hold valid/op/data until ready.
- rsp is not back-pressured; clients must accept it.
- Latency: handshake at edge k, stack strobe during cycle k+1, rsp_valid during cycle k+2. Peak throughput is one op per 3 cycles.
- Round-robin:
  - Priority pointer starts at the client after the last granted one, wrapping NUM_CLIENTS-1 -> 0.
  - The pointer updates only on a handshake.
  - After reset, client 0 has highest priority.
- count:
  - Increments on a successful push and decrements on a successful pop.
  - Saturates by construction: it never exceeds 2**ADDR_SPACE_EXP and never goes below 0.
  - It must equal the stack's true occupancy at all times.
- Simultaneous requests: exactly one grant; the others wait, with no loss or duplication.
- A client whose req_valid drops before it is granted is simply skipped.
- Reset values: state IDLE, pointer 0, req_ready 0, rsp_valid 0, rsp_data 0, rsp_err 0, count 0; the stack is empty, so empty = 1 and full = 0.
- Reset mid-operation (in EXEC or RESP): abort, no rsp_valid, return to IDLE. Stack contents are cleared by the shared reset.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE, ST_EXEC, ST_RESP;
  - OP_PUSH = 1 and OP_POP = 0;
  - the depth constant 2**ADDR_SPACE_EXP.
- One natural sub-module: rr_arbiter. It is parameterised by NUM_CLIENTS, takes req, advance and clk/reset, and outputs a one-hot grant plus an encoded index.
- The stack is instantiated unchanged, with DATA_SIZE and ADDR_SPACE_EXP forwarded.

Test Plan:
- Single push then pop: client 0 pushes 8'hA5 -> rsp_valid[0] two cycles after the handshake, rsp_err = 0, count = 1. Client 0 then pops -> rsp_data = 8'hA5, count = 0, empty = 1.
- Round-robin fairness: both clients hold req_valid continuously, pushing 8'h11 (client 0) and 8'h22 (client 1) -> grants alternate 0,1,0,1. After 4 ops, full = 1 and count = 4.
- LIFO order through the arbiter: push 8'h00, 8'hF0, 8'h0F, 8'hAA, then 4 pops -> rsp_data = 8'hAA, 8'h0F, 8'hF0, 8'h00.
- Overflow/underflow: with the stack full, push 8'hBC -> rsp_err = 1, count stays 4, the next pop returns the previous top. With the stack empty, pop -> rsp_err = 1, rsp_data = 0, count stays 0.
- Mid-op reset: assert reset during EXEC of a push -> no rsp_valid, count = 0, empty = 1, next grant goes to client 0.
- Withdrawn request: client 1 raises then drops req_valid while client 0's op is in progress -> client 1 never receives a grant or a response.
